int_logic_arb: RTL and testbench
================================

INT_LOGIC_ARB -- requirements
Module: int_logic_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 16: maximum WAIT cycles before an error response; legal range 2..255.
REQ-003 clk  in  1  the single clock; all state updates on the posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  NREQ  per-requester operation request.
REQ-006 req_ready  out  NREQ  one-hot grant/accept; request i is accepted when req_valid[i] and req_ready[i] are both high.
REQ-007 req_a, req_b  in  NREQ*32 each  operands; requester i occupies bits [32i+31:32i].
REQ-008 req_op  in  NREQ*2  per-requester op: 0=OR, 1=AND, 2=SLT (unsigned), 3=illegal.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  response consumer accepts.
REQ-011 rsp_id  out  clog2(NREQ)  index of the requester that owns the response.
REQ-012 rsp_data  out  32  result.
REQ-013 rsp_err  out  1  the op was illegal or timed out.
REQ-014 lu_ce  out  1  clock enable to the shared logic unit.
REQ-015 lu_a, lu_b  out  32 each; lu_ctrl  out  2  operands and op code to the unit.
REQ-016 lu_ready  in  1; lu_dout  in  32; lu_done  in  1  unit status, result and completion.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one operation is in flight at any time.
REQ-019 IDLE: if any req_valid is high, grant round-robin starting at (last_grant+1) mod NREQ; req_ready of the winner goes high combinationally in the same cycle; no other req_ready bit is high.
REQ-020 On acceptance, latch A, B, op and the requester id; update last_grant to the winner.
REQ-021 IDLE with an accepted op==3: go to RESP with rsp_err=1 and rsp_data=0; lu_ce is never asserted for that op.
REQ-022 IDLE with an accepted legal op: go to ISSUE if lu_ready=1; otherwise go to ISSUE once lu_ready rises, with the latched operands held.
REQ-023 ISSUE lasts 1 cycle: lu_ce=1, lu_a/lu_b/lu_ctrl are driven from the latches; next state is WAIT.
REQ-024 WAIT: lu_ce stays 1 and the operands stay stable; a 8-bit counter starting at 0 increments each cycle.
REQ-025 WAIT with lu_done=1: capture lu_dout into rsp_data, set rsp_err=0, go to RESP.
REQ-026 If lu_done is seen and the counter reaches TIMEOUT-1 in the same cycle, completion wins.
REQ-027 WAIT with the counter reaching TIMEOUT-1 and lu_done=0: set rsp_data=0 and rsp_err=1, then go to RESP.
REQ-028 RESP: lu_ce=0 and rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_valid and rsp_ready are both high, then the FSM goes to IDLE.
REQ-029 lu_ce is low for at least 1 cycle between consecutive ops, so the unit clears done and dout.
REQ-030 With a zero-latency unit and rsp_ready held at 1, there are 4 cycles per op: IDLE, ISSUE, WAIT, RESP.
REQ-031 req_ready is 0 in every non-IDLE state; requests arriving during an op wait, and no request is dropped.
REQ-032 Outside ISSUE and WAIT, lu_a, lu_b and lu_ctrl hold their last values and lu_ce is 0.

Reset
REQ-033 While rst=1 at a posedge, the FSM goes to IDLE and last_grant goes to NREQ-1, so requester 0 has priority first.
REQ-034 The same reset clears the counter and sets rsp_valid, rsp_err, rsp_data, rsp_id, lu_ce, lu_a, lu_b, lu_ctrl, req_ready and busy to 0.
REQ-035 Reset mid-operation abandons the op without a response; lu_ce drops the next cycle.

Structure
REQ-036 The shared package int_pkg holds the op enum (OP_OR=0, OP_AND=1, OP_SLT=2, OP_ILL=3), the FSM state enum and the default TIMEOUT constant.
REQ-037 Round-robin selection is one sub-module, rr_arbiter (NREQ req bits in, pointer in, one-hot grant plus index out), and it is purely combinational.

Verification
REQ-038 Single op: req 1 sends A=0xF0F0_0000, B=0x0F0F_00FF, op=0 with the real unit -> rsp_id=1, rsp_data=0xFFFF_00FF, rsp_err=0, 4 cycles from accept to handshake.
REQ-039 All 4 requesters valid continuously after reset -> grant order 0,1,2,3,0; no requester starved; each ID's result is correct (AND/SLT mix).
REQ-040 op=3 from req 2 -> rsp_err=1, rsp_data=0, lu_ce never high during that op.
REQ-041 Stub unit with lu_done tied low, TIMEOUT=16 -> rsp_err=1 exactly 16 WAIT cycles after ISSUE; the next op proceeds normally.
REQ-042 rsp_ready held low 10 cycles -> rsp_* stable, all req_ready=0; then rst=1 mid-WAIT on a new op -> all outputs 0 the next cycle and no response emitted.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types for the integer logic-unit arbiter: op codes, FSM states, default timeout.
package int_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_SLT = 2'd2,
        OP_ILL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit at or after ptr, wrapping; one-hot grant plus index.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
    parameter int  NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/int_logic_arb.sv
// Arbitrates NREQ requesters onto one shared OR/AND/SLT logic unit, one op in flight.
// Latency: 4 cycles per op (IDLE, ISSUE, WAIT, RESP) with a zero-latency unit; WAIT bounded by TIMEOUT.
// Backpressure: req_ready only in IDLE; RESP holds until rsp_ready; ISSUE stalls while lu_ready is low.
module int_logic_arb
    import int_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  TIMEOUT = DEFAULT_TIMEOUT,
    localparam int IW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              lu_ce,
    output logic [31:0]       lu_a,
    output logic [31:0]       lu_b,
    output logic [1:0]        lu_ctrl,
    input  logic              lu_ready,
    input  logic [31:0]       lu_dout,
    input  logic              lu_done,
    output logic              busy
);

    state_e          state;
    state_e          state_nxt;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   win_idx;
    logic            any_req;
    logic            accept;
    op_e             win_op;
    logic [31:0]     win_a;
    logic [31:0]     win_b;
    logic [7:0]      wait_cnt;
    logic            timed_out;

    assign rr_ptr = (last_grant == IW'(NREQ - 1)) ? '0 : last_grant + IW'(1);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .any       (any_req)
    );

    // Gated by rst so nothing looks accepted on a cycle that reset discards.
    assign accept    = (state == IDLE) && any_req && !rst;
    assign req_ready = accept ? grant : '0;
    assign win_a     = req_a[int'(win_idx)*32 +: 32];
    assign win_b     = req_b[int'(win_idx)*32 +: 32];
    assign win_op    = op_e'(req_op[int'(win_idx)*2 +: 2]);
    assign timed_out = (wait_cnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        lu_ce     = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) state_nxt = (win_op == OP_ILL) ? RESP : ISSUE;
            end
            ISSUE: begin
                // A not-ready unit keeps us here with lu_ce low and operands parked.
                lu_ce = lu_ready;
                if (lu_ready) state_nxt = WAIT;
            end
            WAIT: begin
                lu_ce = 1'b1;
                if (lu_done || timed_out) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(NREQ - 1);
            wait_cnt   <= 8'd0;
            rsp_id     <= '0;
            rsp_data   <= 32'd0;
            rsp_err    <= 1'b0;
            lu_a       <= 32'd0;
            lu_b       <= 32'd0;
            lu_ctrl    <= 2'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : 8'd0;
            if (accept) begin
                last_grant <= win_idx;
                rsp_id     <= win_idx;
                if (win_op == OP_ILL) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= 32'd0;
                end else begin
                    lu_a    <= win_a;
                    lu_b    <= win_b;
                    lu_ctrl <= win_op;
                end
            end
            // Completion takes priority over a timeout landing on the same cycle.
            if (state == WAIT) begin
                if (lu_done) begin
                    rsp_data <= lu_dout;
                    rsp_err  <= 1'b0;
                end else if (timed_out) begin
                    rsp_data <= 32'd0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_int_logic_arb.sv
// Randomized self-checking bench for int_logic_arb with a behavioural logic unit and reference model.
module tb_int_logic_arb;

    localparam int NREQ = 4;
    localparam int TO   = 16;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } op_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [7:0]   req_op = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         lu_ce;
    logic [31:0]  lu_a;
    logic [31:0]  lu_b;
    logic [1:0]   lu_ctrl;
    logic         lu_ready = 1'b1;
    logic [31:0]  lu_dout = '0;
    logic         lu_done = 1'b0;
    logic         busy;

    int  n_checks = 0;
    int  n_pass = 0;
    bit  u_stub = 1'b0;
    int  u_lat = 0;
    int  u_cnt = 0;
    int  mdl_last;
    op_t pq[4][$];

    always #5 clk = ~clk;

    int_logic_arb #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .lu_ce(lu_ce), .lu_a(lu_a), .lu_b(lu_b), .lu_ctrl(lu_ctrl),
        .lu_ready(lu_ready), .lu_dout(lu_dout), .lu_done(lu_done), .busy(busy)
    );

    function automatic logic [31:0] lu_func(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Logic unit: result appears u_lat cycles after the first enabled cycle; cleared whenever ce drops.
    always @(posedge clk) begin
        if (!lu_ce) begin
            u_cnt   <= 0;
            lu_done <= 1'b0;
            lu_dout <= 32'd0;
        end else begin
            u_cnt <= u_cnt + 1;
            if (!u_stub && u_cnt >= u_lat) begin
                lu_done <= 1'b1;
                lu_dout <= lu_func(lu_ctrl, lu_a, lu_b);
            end
        end
    end

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a  = $urandom;
        o.b  = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
        o.op = 2'($urandom_range(0, 3));
        return o;
    endfunction

    task automatic load_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_op[id*2 +: 2]  = op;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drives one op from requester id and reports what the DUT produced.
    task automatic do_one(input int id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          output logic [1:0] o_id, output logic [31:0] o_data, output logic o_err,
                          output int o_cyc, output int o_ce, output logic [31:0] o_lua,
                          output logic [1:0] o_ctrl, output bit o_to);
        bit acc;
        bit seen_ce;
        acc = 0; seen_ce = 0; o_cyc = 0; o_ce = 0; o_to = 1;
        o_id = '0; o_data = '0; o_err = 1'b0; o_lua = '0; o_ctrl = '0;
        load_req(id, a, b, op);
        req_valid[id] = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 100 && o_to; c++) begin
            @(negedge clk);
            if (lu_ce) begin
                if (!seen_ce) begin o_lua = lu_a; o_ctrl = lu_ctrl; end
                seen_ce = 1;
                o_ce++;
            end
            if (!acc && req_ready[id]) acc = 1;
            if (acc) o_cyc++;
            if (rsp_valid && rsp_ready) begin
                o_id = rsp_id; o_data = rsp_data; o_err = rsp_err; o_to = 0;
            end
            @(posedge clk); #1;
            if (acc) req_valid[id] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_err, rsp_id, lu_ce, lu_ctrl, req_ready, busy} !== 12'd0)
            $display("FAIL reset_ctrl: got %b want 0", {rsp_valid, rsp_err, rsp_id, lu_ce, lu_ctrl, req_ready, busy}); else n_pass++;
        n_checks++; if (rsp_data !== 32'd0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
        n_checks++; if (lu_a !== 32'd0) $display("FAIL reset_lu_a: got %h want 0", lu_a); else n_pass++;
        n_checks++; if (lu_b !== 32'd0) $display("FAIL reset_lu_b: got %h want 0", lu_b); else n_pass++;
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] id; logic [31:0] d; logic e; int cyc; int ce; logic [31:0] la; logic [1:0] lc; bit to;
        pulse_reset();
        u_stub = 0; u_lat = 0; lu_ready = 1;
        do_one(1, 32'hF0F0_0000, 32'h0F0F_00FF, 2'd0, id, d, e, cyc, ce, la, lc, to);
        n_checks++; if (to !== 1'b0) $display("FAIL single_timeout: no response within budget"); else n_pass++;
        n_checks++; if (id !== 2'd1) $display("FAIL single_id: got %0d want 1", id); else n_pass++;
        n_checks++; if (d !== 32'hFFFF_00FF) $display("FAIL single_data: got %h want ffff00ff", d); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL single_err: got %b want 0", e); else n_pass++;
        n_checks++; if (cyc != 4) $display("FAIL single_cycles: got %0d want 4", cyc); else n_pass++;
        n_checks++; if (ce != 2) $display("FAIL single_ce_cycles: got %0d want 2", ce); else n_pass++;
        n_checks++; if (la !== 32'hF0F0_0000) $display("FAIL single_lu_a: got %h want f0f00000", la); else n_pass++;
        n_checks++; if (lc !== 2'd0) $display("FAIL single_lu_ctrl: got %0d want 0", lc); else n_pass++;
        // Unit not ready at accept: the op must wait and still complete correctly.
        lu_ready = 0;
        fork
            begin repeat (6) @(posedge clk); #1 lu_ready = 1; end
        join_none
        do_one(2, 32'd5, 32'd9, 2'd2, id, d, e, cyc, ce, la, lc, to);
        n_checks++; if ({to, id, d, e} !== {1'b0, 2'd2, 32'd1, 1'b0})
            $display("FAIL stall_rsp: got to=%b id=%0d data=%h err=%b want 0/2/1/0", to, id, d, e); else n_pass++;
        n_checks++; if (ce != 2) $display("FAIL stall_ce_cycles: got %0d want 2", ce); else n_pass++;
    endtask

    task automatic test_round_robin();
        int   exp_ord[5] = '{0, 1, 2, 3, 0};
        int   order[$];
        rsp_t exp_q[$];
        rsp_t r;
        int   w;
        int   nresp;
        pulse_reset();
        u_stub = 0; u_lat = 0; lu_ready = 1; rsp_ready = 1;
        for (int i = 0; i < NREQ; i++) load_req(i, $urandom, $urandom, (i % 2 == 0) ? 2'd1 : 2'd2);
        req_valid = 4'hF;
        nresp = 0;
        for (int c = 0; c < 200 && nresp < 5; c++) begin
            @(negedge clk);
            w = -1;
            if ((req_valid & req_ready) != 0) begin
                n_checks++; if ($countones(req_ready) != 1) $display("FAIL rr_onehot: got %b want one-hot", req_ready); else n_pass++;
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) w = k;
                order.push_back(w);
                r.id = 2'(w); r.err = 1'b0;
                r.data = lu_func(req_op[w*2 +: 2], req_a[w*32 +: 32], req_b[w*32 +: 32]);
                exp_q.push_back(r);
            end
            if (rsp_valid && rsp_ready) begin
                r = exp_q.pop_front();
                nresp++;
                n_checks++; if ({rsp_id, rsp_data, rsp_err} !== {r.id, r.data, r.err})
                    $display("FAIL rr_rsp: got id=%0d data=%h err=%b want id=%0d data=%h err=%b", rsp_id, rsp_data, rsp_err, r.id, r.data, r.err); else n_pass++;
            end
            @(posedge clk); #1;
            if (w >= 0) load_req(w, $urandom, $urandom, $urandom_range(1, 2));
        end
        req_valid = '0;
        n_checks++; if (order.size() < 5) $display("FAIL rr_count: got %0d grants want 5", order.size()); else n_pass++;
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            n_checks++; if (order[k] != exp_ord[k]) $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_ord[k]); else n_pass++;
        end
    endtask

    task automatic test_illegal();
        logic [1:0] id; logic [31:0] d; logic e; int cyc; int ce; logic [31:0] la; logic [1:0] lc; bit to;
        pulse_reset();
        u_stub = 0; u_lat = 0; lu_ready = 1;
        do_one(0, 32'h1234_5678, 32'hFFFF_0000, 2'd1, id, d, e, cyc, ce, la, lc, to);
        n_checks++; if (d !== 32'h1234_0000) $display("FAIL pre_illegal_data: got %h want 12340000", d); else n_pass++;
        do_one(2, $urandom, $urandom, 2'd3, id, d, e, cyc, ce, la, lc, to);
        n_checks++; if (to !== 1'b0) $display("FAIL illegal_timeout: no response within budget"); else n_pass++;
        n_checks++; if (id !== 2'd2) $display("FAIL illegal_id: got %0d want 2", id); else n_pass++;
        n_checks++; if (e !== 1'b1) $display("FAIL illegal_err: got %b want 1", e); else n_pass++;
        n_checks++; if (d !== 32'd0) $display("FAIL illegal_data: got %h want 0", d); else n_pass++;
        n_checks++; if (ce != 0) $display("FAIL illegal_ce: got %0d cycles want 0", ce); else n_pass++;
        n_checks++; if (cyc != 2) $display("FAIL illegal_cycles: got %0d want 2", cyc); else n_pass++;
        n_checks++; if ({lu_ctrl, lu_a} !== {2'd1, 32'h1234_5678})
            $display("FAIL illegal_lu_hold: got ctrl=%0d a=%h want 1/12345678", lu_ctrl, lu_a); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [1:0] id; logic [31:0] d; logic e; int cyc; int ce; logic [31:0] la; logic [1:0] lc; bit to;
        pulse_reset();
        lu_ready = 1;
        u_stub = 1;
        do_one(0, 32'hAAAA_0000, 32'h0000_5555, 2'd0, id, d, e, cyc, ce, la, lc, to);
        u_stub = 0;
        n_checks++; if ({to, e, d} !== {1'b0, 1'b1, 32'd0}) $display("FAIL tmo_rsp: got to=%b err=%b data=%h want 0/1/0", to, e, d); else n_pass++;
        n_checks++; if (ce != TO + 1) $display("FAIL tmo_ce_cycles: got %0d want %0d", ce, TO + 1); else n_pass++;
        n_checks++; if (cyc != TO + 3) $display("FAIL tmo_cycles: got %0d want %0d", cyc, TO + 3); else n_pass++;
        u_lat = 0;
        do_one(1, 32'hFF00_FF00, 32'h0FF0_0FF0, 2'd1, id, d, e, cyc, ce, la, lc, to);
        n_checks++; if ({to, id, e, d} !== {1'b0, 2'd1, 1'b0, 32'h0F00_0F00})
            $display("FAIL tmo_next: got to=%b id=%0d err=%b data=%h want 0/1/0/0f000f00", to, id, e, d); else n_pass++;
        n_checks++; if (cyc != 4) $display("FAIL tmo_next_cycles: got %0d want 4", cyc); else n_pass++;
        // Result landing on the last allowed WAIT cycle wins; one cycle later is a timeout.
        u_lat = TO - 1;
        do_one(2, 32'd3, 32'd7, 2'd0, id, d, e, cyc, ce, la, lc, to);
        n_checks++; if ({to, e, d} !== {1'b0, 1'b0, 32'd7}) $display("FAIL tmo_edge_done: got to=%b err=%b data=%h want 0/0/7", to, e, d); else n_pass++;
        u_lat = TO;
        do_one(3, 32'd3, 32'd7, 2'd0, id, d, e, cyc, ce, la, lc, to);
        n_checks++; if ({to, e, d} !== {1'b0, 1'b1, 32'd0}) $display("FAIL tmo_edge_late: got to=%b err=%b data=%h want 0/1/0", to, e, d); else n_pass++;
        u_lat = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        logic [31:0] b;
        logic [39:0] exp_v;
        bit got;
        bit acc;
        int nce;
        int nbad;
        pulse_reset();
        u_stub = 0; u_lat = 0; lu_ready = 1;
        a = $urandom; b = $urandom;
        load_req(3, a, b, 2'd1);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        got = 0; acc = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (req_ready[3]) acc = 1;
            if (rsp_valid) got = 1;
            @(posedge clk); #1;
            if (acc) req_valid[3] = 1'b0;
        end
        n_checks++; if (!got) $display("FAIL bp_rsp_seen: got none want rsp_valid"); else n_pass++;
        req_valid = 4'b0111;
        exp_v = {1'b1, 4'b0000, 2'd3, 1'b0, a & b};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++; if ({rsp_valid, req_ready, rsp_id, rsp_err, rsp_data} !== exp_v)
                $display("FAIL bp_hold[%0d]: got %h want %h", k, {rsp_valid, req_ready, rsp_id, rsp_err, rsp_data}, exp_v); else n_pass++;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        // New op parked in WAIT by a silent unit, then reset underneath it.
        u_stub = 1;
        load_req(0, $urandom, $urandom, 2'd0);
        req_valid = 4'b0001;
        acc = 0; nce = 0;
        for (int c = 0; c < 50 && nce < 5; c++) begin
            @(negedge clk);
            if (req_ready[0]) acc = 1;
            if (lu_ce) nce++;
            @(posedge clk); #1;
            if (acc) req_valid[0] = 1'b0;
        end
        n_checks++; if (nce < 5) $display("FAIL abort_wait_reached: got %0d ce cycles want 5", nce); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_err, rsp_id, lu_ce, lu_ctrl, req_ready, busy, rsp_data, lu_a, lu_b} !== 108'd0)
            $display("FAIL abort_outputs: got valid=%b err=%b id=%0d ce=%b busy=%b data=%h lu_a=%h want all 0", rsp_valid, rsp_err, rsp_id, lu_ce, busy, rsp_data, lu_a); else n_pass++;
        nbad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid || lu_ce) nbad++;
        end
        n_checks++; if (nbad != 0) $display("FAIL abort_no_rsp: got %0d active cycles want 0", nbad); else n_pass++;
        u_stub = 0;
    endtask

    task automatic test_random();
        rsp_t exp_q[$];
        rsp_t r;
        op_t  o;
        int   w;
        int   lat;
        int   made;
        int   nresp;
        pulse_reset();
        mdl_last = NREQ - 1;
        u_stub = 0; u_lat = 0; lu_ready = 1; rsp_ready = 1;
        made = 0; nresp = 0;
        for (int c = 0; c < 4000 && nresp < 40; c++) begin
            @(negedge clk);
            w = -1;
            if (!busy && req_valid != 0) begin
                w = rr_pick(req_valid, mdl_last);
                n_checks++; if (req_ready !== (4'b0001 << w)) $display("FAIL rand_grant: got %b want %b", req_ready, 4'b0001 << w); else n_pass++;
                o = pq[w][0];
                lat = $urandom_range(0, TO + 2);
                u_lat = lat;
                r.id = 2'(w);
                r.err = (o.op == 2'd3) || (lat > TO - 1);
                r.data = r.err ? 32'd0 : lu_func(o.op, o.a, o.b);
                exp_q.push_back(r);
                mdl_last = w;
            end else if (busy && req_ready != 0) begin
                n_checks++; $display("FAIL rand_busy_ready: got %b want 0", req_ready);
            end
            if (rsp_valid && rsp_ready) begin
                nresp++;
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL rand_rsp: got unexpected response id=%0d want none", rsp_id);
                else begin
                    r = exp_q.pop_front();
                    if ({rsp_id, rsp_data, rsp_err} !== {r.id, r.data, r.err})
                        $display("FAIL rand_rsp: got id=%0d data=%h err=%b want id=%0d data=%h err=%b", rsp_id, rsp_data, rsp_err, r.id, r.data, r.err);
                    else n_pass++;
                end
            end
            @(posedge clk); #1;
            if (w >= 0) void'(pq[w].pop_front());
            if (made < 40 && $urandom_range(0, 2) == 0) begin
                pq[$urandom_range(0, 3)].push_back(rand_op());
                made++;
            end
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (pq[i].size() != 0);
                if (pq[i].size() != 0) load_req(i, pq[i][0].a, pq[i][0].b, pq[i][0].op);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            lu_ready  = ($urandom_range(0, 3) != 0);
        end
        n_checks++; if (nresp != 40) $display("FAIL rand_count: got %0d responses want 40", nresp); else n_pass++;
        req_valid = '0; rsp_ready = 1; lu_ready = 1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_illegal();
        test_timeout();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
